// File: rtl/div_32_iter.sv
// Iterative signed divider using restoring division, one quotient bit per clock.
// A start pulse from any state restarts the operation; RDY pulses once, WIDTH+1 edges after start.
module div_32_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH:0]   r_divisor;
  logic [WIDTH-1:0] r_quo;
  logic             r_sign_q;
  logic             r_divzero;
  logic [WIDTH-1:0] r_result;
  logic             r_exception;
  logic             r_rdy;

  logic [WIDTH:0]   w_abs_a;
  logic [WIDTH:0]   w_abs_b;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_rem_nx;
  logic             w_ge;
  logic [WIDTH-1:0] w_quo_neg;

  // Operand magnitudes and one restoring step; r_quo shifts the dividend out of its MSB
  // while the new quotient bits shift in at the LSB.
  always_comb begin
    w_abs_a   = {1'b0, data_operandA};
    w_abs_b   = {1'b0, data_operandB};
    w_rem_sh  = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    w_ge      = (w_rem_sh >= r_divisor);
    w_rem_nx  = w_rem_sh;
    w_quo_neg = ~r_quo + {{(WIDTH-1){1'b0}}, 1'b1};
    if (data_operandA[WIDTH-1]) begin
      w_abs_a = ~{1'b1, data_operandA} + {{WIDTH{1'b0}}, 1'b1};
    end else begin
      w_abs_a = {1'b0, data_operandA};
    end
    if (data_operandB[WIDTH-1]) begin
      w_abs_b = ~{1'b1, data_operandB} + {{WIDTH{1'b0}}, 1'b1};
    end else begin
      w_abs_b = {1'b0, data_operandB};
    end
    if (w_ge) begin
      w_rem_nx = w_rem_sh - r_divisor;
    end else begin
      w_rem_nx = w_rem_sh;
    end
  end

  // Control FSM and datapath registers; a start pulse overrides whatever is in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= {CW{1'b0}};
      r_rem       <= {(WIDTH+1){1'b0}};
      r_divisor   <= {(WIDTH+1){1'b0}};
      r_quo       <= {WIDTH{1'b0}};
      r_sign_q    <= 1'b0;
      r_divzero   <= 1'b0;
      r_result    <= {WIDTH{1'b0}};
      r_exception <= 1'b0;
      r_rdy       <= 1'b0;
    end else if (ctrl_DIV) begin
      r_state     <= ST_RUN;
      r_cnt       <= {CW{1'b0}};
      r_rem       <= {(WIDTH+1){1'b0}};
      r_divisor   <= w_abs_b;
      r_quo       <= w_abs_a[WIDTH-1:0];
      r_sign_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      r_divzero   <= (data_operandB == {WIDTH{1'b0}});
      r_result    <= {WIDTH{1'b0}};
      r_exception <= 1'b0;
      r_rdy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_rdy <= 1'b0;
        end
        ST_RUN: begin
          r_rem <= w_rem_nx;
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          r_rdy <= 1'b0;
          if (r_cnt == LAST_CNT) begin
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_DONE: begin
          // A zero divisor still runs the full iteration so latency stays fixed.
          if (r_divzero) begin
            r_result    <= {WIDTH{1'b0}};
            r_exception <= 1'b1;
          end else begin
            r_result    <= r_sign_q ? w_quo_neg : r_quo;
            r_exception <= 1'b0;
          end
          r_rdy   <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_rdy   <= 1'b0;
        end
      endcase
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exception;
  assign data_resultRDY = r_rdy;

endmodule
